// File: rtl/if_id_stage_if.sv
// if_id_stage_if
//   Bundles the fetch-side inputs and the registered IF/ID outputs of the
//   fetch/decode boundary register.
//   master : drives PC, PC_add_4, Instruct, Stall, Flush, IRQ and CntClr,
//            and observes the IF/ID outputs (PC stage / hazard unit side).
//   slave  : the if_id_stage register itself.
//   CNT_W  : width of the debug event counters; it must match the
//            if_id_stage instance.
interface if_id_stage_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      PC;
  logic [31:0]      PC_add_4;
  logic [31:0]      Instruct;
  logic             Stall;
  logic             Flush;
  logic             IRQ;
  logic             CntClr;
  logic [31:0]      IFID_Instruct;
  logic [31:0]      IFID_PC_add_4;
  logic             IFID_Valid;
  logic             IFID_IRQ;
  logic             IRQPending;
  logic [CNT_W-1:0] StallCnt;
  logic [CNT_W-1:0] FlushCnt;
  logic [CNT_W-1:0] IRQCnt;

  modport master (
    output PC, PC_add_4, Instruct, Stall, Flush, IRQ, CntClr,
    input  IFID_Instruct, IFID_PC_add_4, IFID_Valid, IFID_IRQ, IRQPending,
    input  StallCnt, FlushCnt, IRQCnt
  );

  modport slave (
    input  PC, PC_add_4, Instruct, Stall, Flush, IRQ, CntClr,
    output IFID_Instruct, IFID_PC_add_4, IFID_Valid, IFID_IRQ, IRQPending,
    output StallCnt, FlushCnt, IRQCnt
  );
endinterface

// File: rtl/if_id_stage.sv
// if_id_stage
//   Fetch/decode boundary register of the pipelined MIPS core. Each rising
//   edge it captures the fetched instruction and PC+4, holds on Stall and
//   inserts a bubble on Flush (Flush wins over Stall). External interrupt
//   requests are latched until they can ride on a valid user-mode instruction
//   entering decode. Saturating stall/flush/interrupt counters aid debug.
//   Ports:
//     clk   : system clock, rising edge.
//     reset : asynchronous, active-low; clears all state, dropping any
//             pending interrupt.
//     bus   : if_id_stage_if slave modport (fetch inputs, IF/ID outputs).
//   All outputs come straight from flops.
module if_id_stage #(
  parameter logic [31:0] NOP   = 32'h0000_0000,
  parameter int          CNT_W = 16
) (
  input  logic         clk,
  input  logic         reset,
  if_id_stage_if.slave bus
);

  // Increment by one when enabled, sticking at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic             en);
    logic [CNT_W-1:0] r;
    if (en && (v != {CNT_W{1'b1}})) begin
      r = v + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r = v;
    end
    return r;
  endfunction

  logic [31:0]      instr_d, instr_q;
  logic [31:0]      pc4_d, pc4_q;
  logic             valid_d, valid_q;
  logic             irq_d, irq_q;
  logic             pend_d, pend_q;
  logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_d, flush_cnt_q;
  logic [CNT_W-1:0] irq_cnt_d, irq_cnt_q;

  logic             load_s;
  logic             req_s;
  logic             deliver_s;
  logic             unused_pc_s;

  // Only the supervisor flag of the fetch address matters here.
  assign unused_pc_s = ^bus.PC[30:0];

  // Interrupt qualification: a request (latched or arriving now) is handed
  // to decode only on a real load of a user-mode instruction.
  always_comb begin
    load_s    = ~bus.Flush & ~bus.Stall;
    req_s     = pend_q | bus.IRQ;
    deliver_s = req_s & load_s & ~bus.PC[31];
  end

  // Next-state for pipeline slot, interrupt latch and counters.
  always_comb begin
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    irq_d   = irq_q;
    if (bus.Flush) begin
      // PC+4 still tracks the fetch so exception return addresses stay valid.
      instr_d = NOP;
      pc4_d   = bus.PC_add_4;
      valid_d = 1'b0;
      irq_d   = 1'b0;
    end else if (bus.Stall) begin
      instr_d = instr_q;
      pc4_d   = pc4_q;
      valid_d = valid_q;
      irq_d   = irq_q;
    end else begin
      instr_d = bus.Instruct;
      pc4_d   = bus.PC_add_4;
      valid_d = 1'b1;
      irq_d   = deliver_s;
    end

    pend_d = req_s & ~deliver_s;

    if (bus.CntClr) begin
      stall_cnt_d = {CNT_W{1'b0}};
      flush_cnt_d = {CNT_W{1'b0}};
      irq_cnt_d   = {CNT_W{1'b0}};
    end else begin
      stall_cnt_d = sat_inc(stall_cnt_q, bus.Stall & ~bus.Flush);
      flush_cnt_d = sat_inc(flush_cnt_q, bus.Flush);
      irq_cnt_d   = sat_inc(irq_cnt_q, deliver_s);
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_q     <= NOP;
      pc4_q       <= 32'h0000_0000;
      valid_q     <= 1'b0;
      irq_q       <= 1'b0;
      pend_q      <= 1'b0;
      stall_cnt_q <= {CNT_W{1'b0}};
      flush_cnt_q <= {CNT_W{1'b0}};
      irq_cnt_q   <= {CNT_W{1'b0}};
    end else begin
      instr_q     <= instr_d;
      pc4_q       <= pc4_d;
      valid_q     <= valid_d;
      irq_q       <= irq_d;
      pend_q      <= pend_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      irq_cnt_q   <= irq_cnt_d;
    end
  end

  assign bus.IFID_Instruct = instr_q;
  assign bus.IFID_PC_add_4 = pc4_q;
  assign bus.IFID_Valid    = valid_q;
  assign bus.IFID_IRQ      = irq_q;
  assign bus.IRQPending    = pend_q;
  assign bus.StallCnt      = stall_cnt_q;
  assign bus.FlushCnt      = flush_cnt_q;
  assign bus.IRQCnt        = irq_cnt_q;

endmodule

// File: tb/tb_if_id_stage.sv
// tb_if_id_stage
//   Directed bench for if_id_stage built with 4-bit counters so saturation is
//   reachable. Inputs change 1 time unit after each rising edge; outputs are
//   checked at the same point, one edge after the inputs that produced them.
module tb_if_id_stage;
  localparam int CNT_W = 4;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  if_id_stage_if #(.CNT_W(CNT_W)) bus ();

  if_id_stage #(.NOP(32'h0000_0000), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] pc4, input logic [31:0] ins,
                       input logic st, input logic fl, input logic irq, input logic clr);
    bus.PC       = pc;
    bus.PC_add_4 = pc4;
    bus.Instruct = ins;
    bus.Stall    = st;
    bus.Flush    = fl;
    bus.IRQ      = irq;
    bus.CntClr   = clr;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    drive(32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    chk("rst_instr", bus.IFID_Instruct, 32'h0000_0000);
    chk("rst_valid", {31'd0, bus.IFID_Valid}, 32'd0);
    chk("rst_pend", {31'd0, bus.IRQPending}, 32'd0);
    chk("rst_stallcnt", {28'd0, bus.StallCnt}, 32'd0);

    // First load after release.
    reset = 1'b1;
    drive(32'h0000_0000, 32'h0000_0004, 32'h2008_0005, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("load_instr", bus.IFID_Instruct, 32'h2008_0005);
    chk("load_pc4", bus.IFID_PC_add_4, 32'h0000_0004);
    chk("load_valid", {31'd0, bus.IFID_Valid}, 32'd1);
    chk("load_irq", {31'd0, bus.IFID_IRQ}, 32'd0);

    // Load then stall for three edges with changing Instruct.
    drive(32'h0000_0004, 32'h0000_0008, 32'h0109_5020, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("load2_instr", bus.IFID_Instruct, 32'h0109_5020);
    drive(32'h0000_0008, 32'h0000_000C, 32'hAAAA_0001, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    bus.Instruct = 32'hAAAA_0002;
    tick();
    bus.Instruct = 32'hAAAA_0003;
    tick();
    chk("stall_instr", bus.IFID_Instruct, 32'h0109_5020);
    chk("stall_pc4", bus.IFID_PC_add_4, 32'h0000_0008);
    chk("stall_cnt3", {28'd0, bus.StallCnt}, 32'd3);

    // Flush and Stall together: Flush wins, only FlushCnt counts.
    drive(32'h0000_003C, 32'h0000_0040, 32'hBBBB_0000, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    chk("flush_instr", bus.IFID_Instruct, 32'h0000_0000);
    chk("flush_valid", {31'd0, bus.IFID_Valid}, 32'd0);
    chk("flush_pc4", bus.IFID_PC_add_4, 32'h0000_0040);
    chk("flush_cnt1", {28'd0, bus.FlushCnt}, 32'd1);
    chk("flush_stallcnt", {28'd0, bus.StallCnt}, 32'd3);

    // IRQ pulse in supervisor mode stays pending until a user-mode load.
    drive(32'h8000_0010, 32'h8000_0014, 32'h1111_1111, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    chk("sup_irq", {31'd0, bus.IFID_IRQ}, 32'd0);
    chk("sup_pend", {31'd0, bus.IRQPending}, 32'd1);
    chk("sup_valid", {31'd0, bus.IFID_Valid}, 32'd1);
    drive(32'h0000_0100, 32'h0000_0104, 32'h2222_2222, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("usr_irq", {31'd0, bus.IFID_IRQ}, 32'd1);
    chk("usr_pend", {31'd0, bus.IRQPending}, 32'd0);
    chk("usr_irqcnt", {28'd0, bus.IRQCnt}, 32'd1);
    drive(32'h0000_0104, 32'h0000_0108, 32'h2222_3333, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("after_irq", {31'd0, bus.IFID_IRQ}, 32'd0);
    chk("after_irqcnt", {28'd0, bus.IRQCnt}, 32'd1);

    // IRQ coincident with Flush, then two stalls, then a user-mode load.
    drive(32'h0000_01FC, 32'h0000_0200, 32'h4444_4444, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    chk("fl_irq", {31'd0, bus.IFID_IRQ}, 32'd0);
    chk("fl_pend", {31'd0, bus.IRQPending}, 32'd1);
    chk("fl_cnt2", {28'd0, bus.FlushCnt}, 32'd2);
    drive(32'h0000_0200, 32'h0000_0204, 32'h5555_5555, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    chk("st_irq", {31'd0, bus.IFID_IRQ}, 32'd0);
    chk("st_pend", {31'd0, bus.IRQPending}, 32'd1);
    chk("st_cnt5", {28'd0, bus.StallCnt}, 32'd5);
    drive(32'h0000_0300, 32'h0000_0304, 32'h3333_3333, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("del_irq", {31'd0, bus.IFID_IRQ}, 32'd1);
    chk("del_instr", bus.IFID_Instruct, 32'h3333_3333);
    chk("del_irqcnt", {28'd0, bus.IRQCnt}, 32'd2);
    chk("del_pend", {31'd0, bus.IRQPending}, 32'd0);
    drive(32'h0000_0304, 32'h0000_0308, 32'h6666_6666, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    chk("once_irqcnt", {28'd0, bus.IRQCnt}, 32'd2);

    // Stall saturation: 6 so far + 19 more stall edges -> 15.
    for (int i = 0; i < 19; i++) begin
      tick();
    end
    chk("sat_stallcnt", {28'd0, bus.StallCnt}, 32'd15);
    chk("sat_instr", bus.IFID_Instruct, 32'h3333_3333);
    bus.CntClr = 1'b1;
    tick();
    chk("clr_stallcnt", {28'd0, bus.StallCnt}, 32'd0);
    chk("clr_flushcnt", {28'd0, bus.FlushCnt}, 32'd0);
    chk("clr_irqcnt", {28'd0, bus.IRQCnt}, 32'd0);
    chk("clr_instr", bus.IFID_Instruct, 32'h3333_3333);
    chk("clr_valid", {31'd0, bus.IFID_Valid}, 32'd1);

    // Pending interrupt during a stall, then asynchronous reset.
    drive(32'h8000_0000, 32'h8000_0004, 32'h7777_7777, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    drive(32'h8000_0004, 32'h8000_0008, 32'h8888_8888, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    chk("pre_rst_pend", {31'd0, bus.IRQPending}, 32'd1);
    chk("pre_rst_stallcnt", {28'd0, bus.StallCnt}, 32'd1);
    chk("pre_rst_pc4", bus.IFID_PC_add_4, 32'h8000_0004);
    reset = 1'b0;
    #1;
    chk("arst_instr", bus.IFID_Instruct, 32'h0000_0000);
    chk("arst_pc4", bus.IFID_PC_add_4, 32'h0000_0000);
    chk("arst_valid", {31'd0, bus.IFID_Valid}, 32'd0);
    chk("arst_irq", {31'd0, bus.IFID_IRQ}, 32'd0);
    chk("arst_pend", {31'd0, bus.IRQPending}, 32'd0);
    chk("arst_stallcnt", {28'd0, bus.StallCnt}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
- Fetch/decode boundary register of the pipelined MIPS core; sits directly downstream of the program counter stage and instruction memory.
- Captures the fetched instruction and its PC+4 each cycle, and implements pipeline hold (stall) and bubble insertion (flush).
- Latches external interrupt requests until they can be attached to a valid user-mode instruction entering decode.
- Keeps saturating stall, flush and interrupt event counters for debug.

Parameters:
- NOP, 32'h0000_0000, instruction word inserted on flush/reset (sll $0,$0,0).
- CNT_W, 16, width of each event counter.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-low; asserted (0) clears all state immediately.
- PC  input  32  current fetch address from PC stage; bit 31 = supervisor flag.
- PC_add_4  input  32  PC+4 from PC stage.
- Instruct  input  32  instruction word read at PC this cycle.
- Stall  input  1  hazard unit: hold IF/ID contents.
- Flush  input  1  branch/jump/exception: replace IF/ID contents with bubble.
- IRQ  input  1  external interrupt request (level or single-cycle pulse).
- CntClr  input  1  synchronous clear of all three counters.
- IFID_Instruct  output  32  registered instruction.
- IFID_PC_add_4  output  32  registered PC+4.
- IFID_Valid  output  1  1 = real instruction, 0 = bubble.
- IFID_IRQ  output  1  1 = decode must take interrupt on this slot.
- IRQPending  output  1  latched request not yet delivered.
- StallCnt  output  CNT_W  cycles with Stall applied.
- FlushCnt  output  CNT_W  cycles with Flush applied.
- IRQCnt  output  CNT_W  interrupts delivered.

Behaviour:
- Reset (reset==0, async): IFID_Instruct=NOP, IFID_PC_add_4=0, IFID_Valid=0, IFID_IRQ=0, IRQPending=0, all counters=0. Release is sampled on the next rising edge.
- Per-edge priority: Flush > Stall > load.
- Flush=1: IFID_Instruct=NOP, IFID_Valid=0, IFID_IRQ=0, IFID_PC_add_4=PC_add_4 (kept so exception return addresses remain meaningful).
- Stall=1 (Flush=0): all IFID_* outputs hold their values.
- Load (Flush=0, Stall=0): IFID_Instruct=Instruct, IFID_PC_add_4=PC_add_4, IFID_Valid=1, IFID_IRQ=deliver.
- Latency: one cycle from inputs to IFID_* outputs.
- Interrupt latch:
  - set = IRQ sampled 1 on an edge.
  - deliver = (IRQPending|IRQ) & load & ~PC[31].
  - Next IRQPending = (IRQPending|IRQ) & ~deliver.
  - A request is never lost: if it arrives during Flush, Stall, or supervisor mode (PC[31]=1), it stays pending until the first qualifying load.
  - IRQ held high after delivery re-sets pending on the following edge; level sources must be cleared by the handler.
- Counters:
  - StallCnt increments when Stall & ~Flush.
  - FlushCnt increments when Flush.
  - IRQCnt increments when deliver.
  - Each saturates at all-ones (no wrap).
  - CntClr=1 forces all three to 0 on that edge; it has priority over increment and does not affect the pipeline state or IRQPending.
- Simultaneous Stall+Flush: treated as Flush; only FlushCnt increments.
- Reset mid-stall or with a pending interrupt: everything cleared and the pending request is dropped.
- Outputs are registered only; no combinational path from inputs to outputs.

Test Plan:
- Reset then release; Stall=Flush=0; PC=0x0000_0000, PC_add_4=0x4, Instruct=0x2008_0005 -> after 1 edge IFID_Instruct=0x2008_0005, IFID_PC_add_4=0x4, IFID_Valid=1, IFID_IRQ=0.
- Load 0x0109_5020, then Stall=1 for 3 edges with changing Instruct -> IFID_Instruct stays 0x0109_5020, StallCnt=3.
- Flush=1 and Stall=1 on the same edge, PC_add_4=0x40 -> IFID_Instruct=0, IFID_Valid=0, IFID_PC_add_4=0x40, FlushCnt=1, StallCnt unchanged.
- One-cycle IRQ pulse while PC=0x8000_0010 (supervisor), then PC=0x0000_0100 with a load -> IRQPending=1 until that load; IFID_IRQ=1 on it; IRQPending=0; IRQCnt=1.
- IRQ pulse coincident with Flush, followed by 2 stall cycles and then a user-mode load -> IFID_IRQ=0 during flush and stalls, 1 on the load; delivered exactly once.
- CNT_W=4: 20 consecutive Stall cycles -> StallCnt=15 (saturated); CntClr=1 together with Stall -> StallCnt=0.
- Assert reset while IRQPending=1 and mid-stall -> all outputs at reset values immediately, without waiting for a clock edge.
